// File: rtl/sm83_dffr_and2_in1_n_tap_in1.sv
// -----------------------------------------------------------------------------
// sm83_dffr_and2_in1_n_tap_in1
//
// Registered, WIDTH-bit version of the SM83 "and2 with inverted in1 and in1
// tap" cell. Each bit exposes the inverted active-low input (tap_in1) and its
// AND with the shared enable (y). A state register q is parallel-loaded
// through the same gate. An optional serial-shift mode is available, and a
// one-cycle strobe (chg) flags every edge that altered q.
//
// Ports
//   clk        in   1      state clock, rising edge
//   reset_n    in   1      asynchronous reset, active low
//   in1_n      in   WIDTH  active-low data bus
//   in2        in   1      gate / parallel-load enable, active high
//   shift_en   in   1      shift request (only acted on when SHIFT=1)
//   shift_in   in   1      serial input into bit 0
//   tap_in1    out  WIDTH  ~in1_n (combinational)
//   y          out  WIDTH  tap_in1 & in2 (combinational)
//   q          out  WIDTH  registered state
//   shift_out  out  1      q[WIDTH-1]
//   chg        out  1      high for one cycle after an edge that changed q
// -----------------------------------------------------------------------------
module sm83_dffr_and2_in1_n_tap_in1 #(
   parameter int WIDTH     = 8,
   parameter int SHIFT     = 0,
   parameter int L_y       = 10,
   parameter int L_tap_in1 = 32,
   parameter int L_q       = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in1_n,
   input  logic             in2,
   input  logic             shift_en,
   input  logic             shift_in,
   output logic [WIDTH-1:0] tap_in1,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] q,
   output logic             shift_out,
   output logic             chg
);

   // Elaboration-time legality checks; the load parameters only feed the
   // timing annotation, so they are sanity-checked here as well.
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("WIDTH must be in 1..32");
   end
   if (SHIFT != 0 && SHIFT != 1) begin : g_bad_shift
      $error("SHIFT must be 0 or 1");
   end
   if (L_y < 1 || L_tap_in1 < 1 || L_q < 1) begin : g_bad_load
      $error("load parameters must be positive");
   end

   logic [WIDTH-1:0] q_q, q_d;
   logic             chg_q, chg_d;
   logic [WIDTH-1:0] shifted;
   logic             do_shift;

   // Combinational cell behaviour: a plain inverter and AND, so X on in1_n
   // reaches tap_in1/y as X while in2=0 still forces y to 0.
   assign tap_in1 = ~in1_n;
   assign y       = tap_in1 & {WIDTH{in2}};

   // The WIDTH=1 case has no upper bits to carry; slicing q_q[WIDTH-2:0]
   // would be an illegal range there.
   if (WIDTH == 1) begin : g_shift_w1
      assign shifted = shift_in;
   end else begin : g_shift_wn
      assign shifted = {q_q[WIDTH-2:0], shift_in};
   end

   // With SHIFT=0 this folds to 0 and the shift path disappears.
   assign do_shift = (SHIFT == 1) & shift_en;

   // Shift takes priority over the parallel load; otherwise hold.
   always_comb begin
      q_d = q_q;
      if (do_shift) begin
         q_d = shifted;
      end else if (in2) begin
         q_d = tap_in1;
      end
      chg_d = (q_d != q_q);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q   <= '0;
         chg_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         chg_q <= chg_d;
      end
   end

   assign q         = q_q;
   assign chg       = chg_q;
   assign shift_out = q_q[WIDTH-1];

   // Elmore-model delay annotation shared with the rest of the sm83 cell set.
   // Only compiled in timing-annotated gate-level style builds.
`ifdef SM83_TIMING
   specify
      specparam T_rise_in1  = sm83_timing::tpd_elmore(L_tap_in1, 3*sm83_timing::L_unit, 0);
      specparam T_fall_in1  = sm83_timing::tpd_elmore(L_tap_in1, 0, 3*sm83_timing::L_unit);
      specparam T_rise_nand = sm83_timing::tpd_elmore(40, sm83_timing::L_unit, 0);
      specparam T_fall_nand = sm83_timing::tpd_elmore(40, 0, 2*sm83_timing::L_unit);
      specparam T_rise_y    = sm83_timing::tpd_elmore(L_y, sm83_timing::L_unit, 0);
      specparam T_fall_y    = sm83_timing::tpd_elmore(L_y, 0, sm83_timing::L_unit);
      specparam T_rise_q    = sm83_timing::tpd_elmore(L_q, sm83_timing::L_unit, 0);
      specparam T_fall_q    = sm83_timing::tpd_elmore(L_q, 0, sm83_timing::L_unit);
      (in1_n *> tap_in1)    = (T_rise_in1, T_fall_in1);
      (in1_n *> y)          = (T_rise_in1 + T_fall_nand + T_rise_y,
                               T_fall_in1 + T_rise_nand + T_fall_y);
      (in2 *> y)            = (T_fall_nand + T_rise_y, T_rise_nand + T_fall_y);
      (clk *> q)            = (T_rise_q, T_fall_q);
      (clk => shift_out)    = (T_rise_q, T_fall_q);
      (clk => chg)          = (T_rise_q, T_fall_q);
      (reset_n *> q)        = T_fall_q;
      (reset_n => chg)      = T_fall_q;
   endspecify
`endif

endmodule

// File: tb/tb_sm83_dffr_and2_in1_n_tap_in1.sv
// Scoreboard bench: stimulus pushes expected post-edge values, a monitor pops
// and compares after every rising edge. Three instances: 8-bit shift, 8-bit
// no-shift, and 1-bit shift.
module tb_sm83_dffr_and2_in1_n_tap_in1;
   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] in1_n;
   logic       in2, shift_en, shift_in;

   logic [7:0] tap_a, y_a, q_a;  logic so_a, chg_a;
   logic [7:0] tap_b, y_b, q_b;  logic so_b, chg_b;
   logic       tap_c, y_c, q_c;  logic so_c, chg_c;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sm83_dffr_and2_in1_n_tap_in1 #(.WIDTH(8), .SHIFT(1)) u_a (
      .clk(clk), .reset_n(reset_n), .in1_n(in1_n), .in2(in2),
      .shift_en(shift_en), .shift_in(shift_in), .tap_in1(tap_a), .y(y_a),
      .q(q_a), .shift_out(so_a), .chg(chg_a));

   sm83_dffr_and2_in1_n_tap_in1 #(.WIDTH(8), .SHIFT(0)) u_b (
      .clk(clk), .reset_n(reset_n), .in1_n(in1_n), .in2(in2),
      .shift_en(shift_en), .shift_in(shift_in), .tap_in1(tap_b), .y(y_b),
      .q(q_b), .shift_out(so_b), .chg(chg_b));

   sm83_dffr_and2_in1_n_tap_in1 #(.WIDTH(1), .SHIFT(1)) u_c (
      .clk(clk), .reset_n(reset_n), .in1_n(in1_n[0:0]), .in2(in2),
      .shift_en(shift_en), .shift_in(shift_in), .tap_in1(tap_c), .y(y_c),
      .q(q_c), .shift_out(so_c), .chg(chg_c));

   typedef struct {
      int qa, ca, qb, cb, qc, cc, tap, y;
   } exp_t;
   exp_t sb[$];

   // reference state
   int ma = 0, mb = 0, mc = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Next register value from the behavioural rules, as plain arithmetic.
   function automatic int nxt(input int cur, input int width, input bit shift_ok,
                              input int bus_n, input bit en, input bit sen, input bit sin);
      int mask = (1 << width) - 1;
      if (shift_ok && sen) return (cur * 2 + sin) & mask;
      if (en)              return (~bus_n) & mask;
      return cur;
   endfunction

   // One clock of stimulus: drive at negedge, predict, push.
   task automatic cyc(input int bus_n, input bit en, input bit sen, input bit sin);
      exp_t e;
      int na, nb, nc;
      @(negedge clk);
      in1_n = bus_n[7:0]; in2 = en; shift_en = sen; shift_in = sin;
      na = nxt(ma, 8, 1, bus_n, en, sen, sin);
      nb = nxt(mb, 8, 0, bus_n, en, sen, sin);
      nc = nxt(mc, 1, 1, bus_n, en, sen, sin);
      e.qa = na; e.ca = (na != ma); e.qb = nb; e.cb = (nb != mb);
      e.qc = nc; e.cc = (nc != mc);
      e.tap = (~bus_n) & 255;
      e.y = en ? e.tap : 0;
      ma = na; mb = nb; mc = nc;
      sb.push_back(e);
   endtask

   task automatic drain();
      int budget = 20;
      while (sb.size() != 0 && budget > 0) begin
         @(posedge clk); #3;
         budget--;
      end
      chk("drain_timeout", sb.size(), 0);
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #2;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("q_a", q_a, e.qa);       chk("chg_a", chg_a, e.ca);
            chk("so_a", so_a, e.qa >> 7);
            chk("q_b", q_b, e.qb);       chk("chg_b", chg_b, e.cb);
            chk("q_c", q_c, e.qc);       chk("chg_c", chg_c, e.cc);
            chk("so_c", so_c, e.qc);
            chk("tap_a", tap_a, e.tap);  chk("y_a", y_a, e.y);
            chk("y_c", y_c, e.y & 1);
         end
      end
   end

   initial begin
      reset_n = 1'b0; in1_n = 8'hFF; in2 = 0; shift_en = 0; shift_in = 0;
      #12 reset_n = 1'b1;
      // Load A5 then reset asynchronously mid-cycle.
      cyc(8'h5A, 1, 0, 0);
      drain();
      chk("preload_q_a", q_a, 8'hA5);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_q_a", q_a, 0); chk("rst_chg_a", chg_a, 0); chk("rst_so_a", so_a, 0);
      chk("rst_q_b", q_b, 0); chk("rst_q_c", q_c, 0);
      ma = 0; mb = 0; mc = 0;
      // Clock edges while held in reset must not load.
      in1_n = 8'h00; in2 = 1;
      repeat (3) @(posedge clk);
      #1 chk("rst_hold_q_a", q_a, 0); chk("rst_hold_chg_a", chg_a, 0);
      // Combinational paths with no clock dependency.
      in1_n = 8'h3C; in2 = 0; #1;
      chk("comb_tap", tap_a, 8'hC3); chk("comb_y0", y_a, 8'h00);
      in2 = 1; #1;
      chk("comb_y1", y_a, 8'hC3); chk("comb_tap_b", tap_b, 8'hC3);
      @(negedge clk); reset_n = 1'b1; in2 = 0;

      // Directed scoreboard sequence.
      cyc(8'h0F, 1, 0, 0);   // load F0, chg
      cyc(8'h0F, 1, 0, 0);   // same value, chg=0
      cyc(8'h00, 0, 0, 0);   // hold
      cyc(8'h7E, 1, 0, 0);   // q=81
      cyc(8'h00, 1, 1, 0);   // shift wins: 02 (b loads FF)
      cyc(8'hFE, 1, 1, 1);   // b loads 01; a shifts
      cyc(8'hFF, 0, 1, 1);   // c shifts in 1
      for (int i = 0; i < 300; i++)
         cyc($urandom_range(0, 255), 1'($urandom), 1'($urandom), 1'($urandom));
      drain();

      // Reset between edges, then a normal load on the next edge.
      @(negedge clk); in2 = 0; shift_en = 0;
      #2 reset_n = 1'b0;
      #1 chk("mid_rst_q_c", q_c, 0); chk("mid_rst_so_c", so_c, 0);
      chk("mid_rst_chg_c", chg_c, 0);
      #1 reset_n = 1'b1;
      ma = 0; mb = 0; mc = 0;
      cyc(8'hFE, 1, 0, 0);   // q_c=1, q_a=01
      cyc(8'hFE, 1, 0, 0);
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1);
   end
endmodule
